// File: rtl/tdpram_rd_pkg.sv
// Shared types for the port-B stream reader: FSM state encoding and skid buffer geometry.
package tdpram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  // Two entries cover the single cycle of RAM read latency at full rate.
  localparam int unsigned BUF_DEPTH = 2;

  localparam int unsigned RD_DATA_W = 32;

  // Buffer entry layout at the default word width.
  typedef struct packed {
    logic                 last;
    logic [RD_DATA_W-1:0] data;
  } rd_entry_t;

endpackage

// File: rtl/tdpram_rd_skid_buf.sv
// Two-entry FIFO that catches RAM read data one cycle after the address was issued.
module tdpram_rd_skid_buf
  import tdpram_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  push_last_i,
  input  logic                  pop_i,
  output logic [1:0]            occ_o,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic                  head_last_o
);

  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] data_a [BUF_DEPTH];
  logic                  last_a [BUF_DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push_i;
    rd_ptr_d = rd_ptr_q ^ pop_i;
    occ_d    = occ_q + 2'(push_i) - 2'(pop_i);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
    logic [DATA_WIDTH-1:0] data_q;
    logic                  last_q;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        data_q <= '0;
        last_q <= 1'b0;
      end else if (push_i && (wr_ptr_q == 1'(gi))) begin
        data_q <= push_data_i;
        last_q <= push_last_i;
      end
    end

    assign data_a[gi] = data_q;
    assign last_a[gi] = last_q;
  end

  assign occ_o       = occ_q;
  assign head_data_o = data_a[rd_ptr_q];
  assign head_last_o = last_a[rd_ptr_q];

endmodule

// File: rtl/tdpram_stream_reader.sv
// Turns (address, length) descriptors into RAM port-B reads and a valid/ready word stream.
// Optional saturating perf counters are built when TDPRAM_RD_PERF_CNT_EN is defined.
module tdpram_stream_reader
  import tdpram_rd_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_ENTRIES = 2048,
  parameter int ADDR_WIDTH  = $clog2(NUM_ENTRIES),
  parameter int LEN_WIDTH   = ADDR_WIDTH + 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  done,
`ifdef TDPRAM_RD_PERF_CNT_EN
  output logic [31:0]           perf_words,
  output logic [31:0]           perf_stalls,
`endif
  output logic                  busy
);

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  pending_q, pending_d;
  logic                  pending_last_q, pending_last_d;
  logic                  done_q, done_d;

  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_last;
  logic                  accept, pop, issue;
  logic [2:0]            fill;

  assign accept = req_valid && req_ready;
  assign pop    = out_valid && out_ready;
  assign fill   = {1'b0, occ} + {2'b0, pending_q};
  // A slot freed by this cycle's pop may be reused, hence the out_ready -> ram_addr path.
  assign issue  = (state_q == READ) && (fill < (3'd2 + {2'b0, pop}));

  always_comb begin
    state_d        = state_q;
    rd_ptr_d       = rd_ptr_q;
    last_addr_d    = last_addr_q;
    remaining_d    = remaining_q;
    pending_d      = issue;
    pending_last_d = issue && (remaining_q == LEN_WIDTH'(1));
    done_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = READ;
            rd_ptr_d    = req_addr;
            remaining_d = req_len;
          end
        end
      end
      READ: begin
        if (issue) begin
          last_addr_d = rd_ptr_q;
          rd_ptr_d    = (rd_ptr_q == ADDR_WIDTH'(NUM_ENTRIES - 1)) ? '0
                                                                  : rd_ptr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      rd_ptr_q       <= '0;
      last_addr_q    <= '0;
      remaining_q    <= '0;
      pending_q      <= 1'b0;
      pending_last_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_ptr_q       <= rd_ptr_d;
      last_addr_q    <= last_addr_d;
      remaining_q    <= remaining_d;
      pending_q      <= pending_d;
      pending_last_q <= pending_last_d;
      done_q         <= done_d;
    end
  end

  tdpram_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clock       (clock),
    .reset_n     (reset_n),
    .push_i      (pending_q),
    .push_data_i (ram_dout),
    .push_last_i (pending_last_q),
    .pop_i       (pop),
    .occ_o       (occ),
    .head_data_o (head_data),
    .head_last_o (head_last)
  );

  assign req_ready = reset_n && (state_q == IDLE);
  assign ram_addr  = issue ? rd_ptr_q : last_addr_q;
  assign ram_we    = 1'b0;
  assign ram_din   = '0;
  assign out_valid = (occ != 2'd0);
  assign out_data  = head_data;
  assign out_last  = out_valid && head_last;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

`ifdef TDPRAM_RD_PERF_CNT_EN
  logic [31:0] perf_words_q, perf_words_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_words_d  = perf_words_q;
    perf_stalls_d = perf_stalls_q;
    if (pop && (perf_words_q != '1)) perf_words_d = perf_words_q + 32'd1;
    if (out_valid && !out_ready && (perf_stalls_q != '1)) perf_stalls_d = perf_stalls_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_words_q  <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_words_q  <= perf_words_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_words  = perf_words_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_tdpram_stream_reader.sv
// Directed bench for tdpram_stream_reader with a 1-cycle-latency RAM model on port B.
module tb_tdpram_stream_reader;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [10:0] req_addr;
  logic [11:0] req_len;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        done;
  logic        busy;
`ifdef TDPRAM_RD_PERF_CNT_EN
  logic [31:0] perf_words;
  logic [31:0] perf_stalls;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] mem [2048];

  tdpram_stream_reader dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .done       (done),
`ifdef TDPRAM_RD_PERF_CNT_EN
    .perf_words (perf_words),
    .perf_stalls(perf_stalls),
`endif
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] word_at(input int a);
    return (32'(a) * 32'h0001_0003) ^ 32'hD000_0000;
  endfunction

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = word_at(i);
  end

  always @(posedge clock) ram_dout <= mem[ram_addr];

  // Handshake lands on the next rising edge; the following negedge is cycle 1.
  task automatic send_req(input int a, input int l);
    @(negedge clock);
    req_valid = 1'b1;
    req_addr  = 11'(a);
    req_len   = 12'(l);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clock);
    tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests_run++; if (out_last !== 1'b0) begin tests_failed++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", done); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests_run++; if (ram_addr !== 11'd0) begin tests_failed++; $display("FAIL reset_ram_addr got=%0d exp=0", ram_addr); end
    tests_run++; if (out_data !== 32'd0) begin tests_failed++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    tests_run++; if (ram_we !== 1'b0 || ram_din !== 32'd0) begin tests_failed++; $display("FAIL reset_ram_wr got we=%b din=%h exp 0/0", ram_we, ram_din); end
    reset_n = 1'b1;
    @(negedge clock);
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_req_ready got=%b exp=1", req_ready); end
    $display("[TB] reset done");
  endtask

  task automatic test_basic();
    logic        exp_v;
    logic [10:0] exp_a;
    out_ready = 1'b1;
    send_req(10, 4);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clock);
      exp_v = (cyc >= 3) && (cyc <= 6);
      tests_run++; if (out_valid !== exp_v) begin tests_failed++; $display("FAIL basic_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_v); end
      if (exp_v) begin
        tests_run++; if (out_data !== word_at(10 + cyc - 3)) begin tests_failed++; $display("FAIL basic_data cyc=%0d got=%h exp=%h", cyc, out_data, word_at(10 + cyc - 3)); end
        tests_run++; if (out_last !== (cyc == 6)) begin tests_failed++; $display("FAIL basic_last cyc=%0d got=%b exp=%b", cyc, out_last, (cyc == 6)); end
      end
      tests_run++; if (done !== (cyc == 7)) begin tests_failed++; $display("FAIL basic_done cyc=%0d got=%b exp=%b", cyc, done, (cyc == 7)); end
      tests_run++; if (busy !== (cyc <= 6)) begin tests_failed++; $display("FAIL basic_busy cyc=%0d got=%b exp=%b", cyc, busy, (cyc <= 6)); end
      if (cyc <= 4) begin
        exp_a = 11'(10 + cyc - 1);
        tests_run++; if (ram_addr !== exp_a) begin tests_failed++; $display("FAIL basic_ram_addr cyc=%0d got=%0d exp=%0d", cyc, ram_addr, exp_a); end
      end
    end
    $display("[TB] basic addr=10 len=4 done");
  endtask

  task automatic test_wrap();
    logic [10:0] exp_addr [4];
    exp_addr[0] = 11'd2046;
    exp_addr[1] = 11'd2047;
    exp_addr[2] = 11'd0;
    exp_addr[3] = 11'd1;
    out_ready = 1'b1;
    send_req(2046, 4);
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clock);
      if (cyc <= 4) begin
        tests_run++; if (ram_addr !== exp_addr[cyc-1]) begin tests_failed++; $display("FAIL wrap_ram_addr cyc=%0d got=%0d exp=%0d", cyc, ram_addr, exp_addr[cyc-1]); end
      end
      if (cyc >= 3 && cyc <= 6) begin
        tests_run++; if (out_valid !== 1'b1 || out_data !== word_at(int'(exp_addr[cyc-3]))) begin
          tests_failed++; $display("FAIL wrap_data cyc=%0d got v=%b d=%h exp v=1 d=%h", cyc, out_valid, out_data, word_at(int'(exp_addr[cyc-3])));
        end
      end
      if (cyc == 7) begin
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL wrap_done got=%b exp=1", done); end
      end
    end
    $display("[TB] wrap addr=2046 len=4 done");
  endtask

  task automatic test_backpressure();
    int n     = 0;
    int dones = 0;
    out_ready = 1'b1;
    send_req(10, 4);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clock);
      out_ready = (cyc % 2) == 1;
      if (done) dones++;
      if (out_valid && out_ready) begin
        tests_run++; if (n >= 4 || out_data !== word_at(10 + n)) begin tests_failed++; $display("FAIL bp_data idx=%0d got=%h exp=%h", n, out_data, word_at(10 + n)); end
        tests_run++; if (out_last !== (n == 3)) begin tests_failed++; $display("FAIL bp_last idx=%0d got=%b exp=%b", n, out_last, (n == 3)); end
        n++;
      end
    end
    out_ready = 1'b1;
    tests_run++; if (n != 4) begin tests_failed++; $display("FAIL bp_word_count got=%0d exp=4", n); end
    tests_run++; if (dones != 1) begin tests_failed++; $display("FAIL bp_done_count got=%0d exp=1", dones); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL bp_busy_end got=%b exp=0", busy); end
    $display("[TB] backpressure len=4 words=%0d", n);
  endtask

  task automatic test_zero_len();
    out_ready = 1'b1;
    send_req(5, 0);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clock);
      tests_run++; if (done !== (cyc == 1)) begin tests_failed++; $display("FAIL zero_done cyc=%0d got=%b exp=%b", cyc, done, (cyc == 1)); end
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL zero_valid cyc=%0d got=%b exp=0", cyc, out_valid); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL zero_busy cyc=%0d got=%b exp=0", cyc, busy); end
    end
    $display("[TB] zero length done");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send_req(0, 100);
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0 || out_last !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_ctrl got v=%b l=%b d=%b b=%b exp all 0", out_valid, out_last, done, busy);
    end
    tests_run++; if (ram_addr !== 11'd0 || out_data !== 32'd0 || req_ready !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_data got a=%0d d=%h rdy=%b exp 0/0/0", ram_addr, out_data, req_ready);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    tests_run++; if (done !== 1'b0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_after got d=%b v=%b exp 0/0", done, out_valid); end
    send_req(500, 1);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clock);
      tests_run++; if (out_valid !== (cyc == 3)) begin tests_failed++; $display("FAIL midrst_len1_valid cyc=%0d got=%b exp=%b", cyc, out_valid, (cyc == 3)); end
      if (cyc == 1) begin
        tests_run++; if (ram_addr !== 11'd500) begin tests_failed++; $display("FAIL midrst_len1_addr got=%0d exp=500", ram_addr); end
      end
      if (cyc == 3) begin
        tests_run++; if (out_data !== word_at(500) || out_last !== 1'b1) begin
          tests_failed++; $display("FAIL midrst_len1_word got d=%h l=%b exp d=%h l=1", out_data, out_last, word_at(500));
        end
      end
      tests_run++; if (done !== (cyc == 4)) begin tests_failed++; $display("FAIL midrst_len1_done cyc=%0d got=%b exp=%b", cyc, done, (cyc == 4)); end
    end
    $display("[TB] reset mid-transfer done");
  endtask

`ifdef TDPRAM_RD_PERF_CNT_EN
  task automatic test_perf();
    int n      = 0;
    int stalls = 0;
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    send_req(100, 8);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clock);
      if (out_valid && cyc >= 4 && stalls < 3) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        tests_run++; if (n >= 8 || out_data !== word_at(100 + n)) begin tests_failed++; $display("FAIL perf_data idx=%0d got=%h exp=%h", n, out_data, word_at(100 + n)); end
        n++;
      end
    end
    out_ready = 1'b1;
    tests_run++; if (perf_words !== 32'd8) begin tests_failed++; $display("FAIL perf_words got=%0d exp=8", perf_words); end
    tests_run++; if (perf_stalls !== 32'd3) begin tests_failed++; $display("FAIL perf_stalls got=%0d exp=3", perf_stalls); end
    $display("[TB] perf len=8 words=%0d stalls=%0d", n, stalls);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
`ifdef TDPRAM_RD_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
